// File: rtl/sysreg_xfer_ctrl_pkg.sv
// rtl/sysreg_xfer_ctrl_pkg.sv - shared encodings and types for the system table register transfer controller
// Contents: FSM state codes (3 bits), register selector codes, RegBus64 type,
// ZeroDWord constant and a selector helper used by the controller.
package sysreg_xfer_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_LO  = 3'd1;
  localparam logic [2:0] ST_RD_HI  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_WR_LO  = 3'd4;
  localparam logic [2:0] ST_WR_HI  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  localparam logic [1:0] SEL_IDT = 2'b00;
  localparam logic [1:0] SEL_GDT = 2'b01;
  localparam logic [1:0] SEL_LDT = 2'b10;
  localparam logic [1:0] SEL_TR  = 2'b11;

  typedef logic [63:0] RegBus64;

  localparam RegBus64 ZeroDWord = 64'h0;

  // Pick one of the four register file values by selector code.
  function automatic RegBus64 sel_reg(input logic [1:0] sel, input RegBus64 idt,
                                      input RegBus64 gdt, input RegBus64 ldt,
                                      input RegBus64 tr);
    RegBus64 r;
    case (sel)
      SEL_IDT: r = idt;
      SEL_GDT: r = gdt;
      SEL_LDT: r = ldt;
      default: r = tr;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sysreg_merge.sv
// rtl/sysreg_merge.sv - combinational 4-way read-modify-write merge for the system register file
// Ports: sel_i selects which register takes new_i; idt_i..tr_i are the current
// values; idt_o..tr_o carry the merged set (unselected registers pass through).
module sysreg_merge
  import sysreg_xfer_ctrl_pkg::*;
(
  input  logic [1:0] sel_i,
  input  RegBus64    new_i,
  input  RegBus64    idt_i,
  input  RegBus64    gdt_i,
  input  RegBus64    ldt_i,
  input  RegBus64    tr_i,
  output RegBus64    idt_o,
  output RegBus64    gdt_o,
  output RegBus64    ldt_o,
  output RegBus64    tr_o
);

  always_comb begin
    idt_o = idt_i;
    gdt_o = gdt_i;
    ldt_o = ldt_i;
    tr_o  = tr_i;
    case (sel_i)
      SEL_IDT: idt_o = new_i;
      SEL_GDT: gdt_o = new_i;
      SEL_LDT: ldt_o = new_i;
      default: tr_o  = new_i;
    endcase
  end

endmodule

// File: rtl/sysreg_xfer_ctrl.sv
// rtl/sysreg_xfer_ctrl.sv - sequences LIDT/LGDT/LLDT/LTR and SIDT/SGDT/SLDT/STR over a 32-bit bus
// Ports: clk/rst (async active-low); req_* from execute, req_ready/stall_o/done_o/err_o
// back to it; mem_* two-beat 32-bit bus (low word first); idt/gdt/ldt/tr_i current
// register file values, sr_we plus idt/gdt/ldt/tr_o register file write port.
module sysreg_xfer_ctrl
  import sysreg_xfer_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_sel,
  input  logic [31:0] req_addr,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  input  logic [63:0] idt_i,
  input  logic [63:0] gdt_i,
  input  logic [63:0] ldt_i,
  input  logic [63:0] tr_i,
  output logic        sr_we,
  output logic [63:0] idt_o,
  output logic [63:0] gdt_o,
  output logic [63:0] ldt_o,
  output logic [63:0] tr_o
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

  logic [2:0]      state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [31:0]     addr_q, addr_d;
  RegBus64         cap_q, cap_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  RegBus64         cur_reg;
  RegBus64         m_idt, m_gdt, m_ldt, m_tr;
  logic            commit;

  // In IDLE the store low word is taken from the incoming selector so it is
  // registered at acceptance; afterwards the latched selector applies.
  assign cur_reg = sel_reg((state_q == ST_IDLE) ? req_sel : sel_q, idt_i, gdt_i, ldt_i, tr_i);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    cap_d       = cap_q;
    to_d        = to_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sel_d      = req_sel;
          addr_d     = req_addr;
          to_d       = '0;
          mem_addr_d = req_addr;
          if (req_addr[1:0] != 2'b00) begin
            state_d = ST_ERR;
          end else if (req_store) begin
            state_d     = ST_WR_LO;
            mem_wdata_d = cur_reg[31:0];
          end else begin
            state_d = ST_RD_LO;
          end
        end
      end
      ST_RD_LO, ST_RD_HI, ST_WR_LO, ST_WR_HI: begin
        // mem_err takes priority over a simultaneous ack.
        if (mem_err) begin
          state_d = ST_ERR;
        end else if (mem_ack) begin
          to_d = '0;
          case (state_q)
            ST_RD_LO: begin
              cap_d[31:0] = mem_rdata;
              mem_addr_d  = addr_q + 32'd4;
              state_d     = ST_RD_HI;
            end
            ST_WR_LO: begin
              mem_wdata_d = cur_reg[63:32];
              mem_addr_d  = addr_q + 32'd4;
              state_d     = ST_WR_HI;
            end
            ST_RD_HI: begin
              cap_d[63:32] = mem_rdata;
              state_d      = ST_COMMIT;
            end
            default: state_d = ST_DONE;
          endcase
        end else if (to_q + 1'b1 == TO_LIMIT) begin
          state_d = ST_ERR;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_IDT;
      addr_q      <= '0;
      cap_q       <= ZeroDWord;
      to_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      cap_q       <= cap_d;
      to_q        <= to_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Strobes decode straight from state so an async reset clears them at once.
  assign req_ready = (state_q == ST_IDLE);
  assign stall_o   = (state_q != ST_IDLE);
  assign mem_req   = (state_q == ST_RD_LO) || (state_q == ST_RD_HI) ||
                     (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
  assign mem_we    = (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
  assign commit    = (state_q == ST_COMMIT);
  assign sr_we     = commit;
  assign done_o    = (state_q == ST_DONE);
  assign err_o     = (state_q == ST_ERR);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  sysreg_merge u_merge (
    .sel_i (sel_q),
    .new_i (cap_q),
    .idt_i (idt_i),
    .gdt_i (gdt_i),
    .ldt_i (ldt_i),
    .tr_i  (tr_i),
    .idt_o (m_idt),
    .gdt_o (m_gdt),
    .ldt_o (m_ldt),
    .tr_o  (m_tr)
  );

  assign idt_o = commit ? m_idt : idt_i;
  assign gdt_o = commit ? m_gdt : gdt_i;
  assign ldt_o = commit ? m_ldt : ldt_i;
  assign tr_o  = commit ? m_tr  : tr_i;

endmodule

// File: doc/sysreg_xfer_ctrl.md
Name: sysreg_xfer_ctrl

Overview:
- Sequences loads and stores of the four 64-bit system table registers (IDT, GDT, LDT, TR) for LIDT/LGDT/LLDT/LTR and SIDT/SGDT/SLDT/STR.
- Sits between the execute stage and the system register file.
- Moves each 64-bit operand over the 32-bit data bus as two beats, low word first.
- Commits loads to the register file with one write strobe, using read-modify-write because the file writes all four registers at once.

Parameters:
- TIMEOUT_CYC, 16: max cycles a bus beat may wait for mem_ack before error.
- TO_W, 5: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request from execute stage.
- req_ready  out  1  high only in IDLE.
- req_store  in  1  0=load into register, 1=store register to memory.
- req_sel  in  2  00 IDT, 01 GDT, 10 LDT, 11 TR.
- req_addr  in  32  memory operand byte address.
- stall_o  out  1  pipeline stall; high whenever state != IDLE.
- done_o  out  1  one-cycle pulse, successful completion.
- err_o  out  1  one-cycle pulse, failed request.
- mem_req  out  1  bus request; held until ack or error.
- mem_we  out  1  bus write.
- mem_addr  out  32  beat address.
- mem_wdata  out  32  store data.
- mem_ack  in  1  beat complete.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_err  in  1  bus fault, valid instead of ack.
- idt_i, gdt_i, ldt_i, tr_i  in  64 each  current register file values.
- sr_we  out  1  register file write enable.
- idt_o, gdt_o, ldt_o, tr_o  out  64 each  register file write data.

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE.
  - mem_req, mem_we, sr_we, done_o and err_o go to 0.
  - mem_addr, mem_wdata, the capture registers and the timeout counter go to 0.
  - Reset mid-transfer abandons the beat immediately and no register file write occurs.
- States: IDLE, RD_LO, RD_HI, COMMIT, WR_LO, WR_HI, DONE, ERR.
- IDLE:
  - A request is accepted on req_valid=1 at a clock edge.
  - sel, store and addr are latched at acceptance.
  - If req_addr[1:0]!=0, go to ERR with no bus activity.
  - Otherwise a load goes to RD_LO and a store goes to WR_LO.
- RD_LO / WR_LO:
  - mem_req=1, mem_addr=addr.
  - On mem_ack, capture the low word (load) or send the selected register's [31:0] (store), then advance to RD_HI / WR_HI.
- RD_HI / WR_HI:
  - mem_addr=addr+4, wrapping modulo 2^32.
  - For a store, mem_wdata holds the selected register's [63:32].
  - Store data is sampled from the *_i inputs when the beat is issued.
- Ack on a HI beat: a load goes to COMMIT, a store goes to DONE.
- COMMIT:
  - sr_we=1 for exactly one cycle.
  - The selected output carries {hi,lo}; the other three outputs carry the *_i values of the same cycle.
  - Then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- ERR: err_o=1 for one cycle, then IDLE; sr_we is never asserted on any error path.
- mem_err on any beat drops mem_req and goes to ERR. If mem_ack and mem_err are both high, mem_err wins.
- Timeout:
  - The counter clears on entry to each beat state and increments each cycle without ack.
  - When it reaches TIMEOUT_CYC it drops mem_req and goes to ERR.
- Outside COMMIT, the *_o outputs pass the *_i values through and sr_we=0.
- Minimum latency with zero-wait ack:
  - Load: accept edge plus 4 cycles to done_o (RD_LO, RD_HI, COMMIT, DONE).
  - Store: accept edge plus 3 cycles to done_o.
- req_valid while busy is ignored. The requester must hold it until it sees req_ready.

Decomposition:
- Shared defines file:
  - state encodings (3 bits);
  - selector codes SEL_IDT/GDT/LDT/TR;
  - existing RegBus64 and ZeroDWord.
- Natural sub-module: sysreg_merge, a combinational 4-way read-modify-write merge that takes sel, the 64-bit new value and the four current values and produces the four outputs.
- The FSM, timeout counter and beat datapath remain in sysreg_xfer_ctrl.

Test Plan:
- LGDT: sel=01, addr=0x1000; rdata 0x89ABCDEF then 0x01234567 with zero-wait acks. Require:
  - beats at 0x1000 and 0x1004;
  - sr_we one cycle with gdt_o=0x0123456789ABCDEF and idt/ldt/tr_o equal to the inputs;
  - done_o 4 cycles after accept.
- SIDT: idt_i=0xDEADBEEF_CAFEF00D, addr=0x2000. Require:
  - writes 0xCAFEF00D@0x2000 then 0xDEADBEEF@0x2004;
  - sr_we never asserted;
  - done_o after 3 cycles.
- Misaligned LTR at addr=0x3002: mem_req never rises, err_o pulses the cycle after accept, no sr_we.
- mem_err on the RD_HI beat of LLDT: err_o pulses, ldt unchanged, and the next request is accepted normally.
- No ack for TIMEOUT_CYC=16 cycles on RD_LO: mem_req drops and err_o pulses. Also check with ack delayed 3 cycles per beat: completes with done_o at accept+10.
- Assert rst=0 asynchronously mid-RD_HI: mem_req drops immediately with no clock edge, no sr_we, and the next request after release completes correctly.
